packet_framer: RTL
==================

PACKET_FRAMER -- requirements
Module: packet_framer

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, output data width in bits (8 bytes per beat).
REQ-002 SHALL have parameter EMPTY_W, default 3, width of the empty field (log2 of bytes per beat).
REQ-003 SHALL have parameter LEN_W, default 16, width of the packet length in bytes.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port srst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cmd_len_i  input  LEN_W, packet length in bytes, and cmd_channel_i  input  1, channel tag.
REQ-007 SHALL have ports cmd_valid_i  input  1 and cmd_ready_o  output  1, command handshake.
REQ-008 SHALL have ports data_i  input  DWIDTH, data_valid_i  input  1 and data_ready_o  output  1, raw payload words with no framing.
REQ-009 SHALL have the Avalon-ST source ports ast_data_o  output  DWIDTH, ast_valid_o  output  1, ast_ready_i  input  1, ast_startofpacket_o  output  1, ast_endofpacket_o  output  1, ast_empty_o  output  EMPTY_W and ast_channel_o  output  1.

Function
REQ-010 SHALL implement FSM IDLE/SEND; cmd_ready_o SHALL be 1 only in IDLE.
REQ-011 On command accept (cmd_valid_i & cmd_ready_o) with cmd_len_i>0: latch beats=ceil(len/8), last_empty=(8-len%8)%8 and channel; go to SEND.
REQ-012 A command with cmd_len_i=0 SHALL be consumed in one cycle, remain in IDLE and produce no output beat.
REQ-013 data_ready_o SHALL equal (state==SEND) & (!ast_valid_o | ast_ready_i).
REQ-014 Each data accept SHALL load the output register on the next edge: data copied, ast_valid_o=1, latency exactly 1 cycle.
REQ-015 ast_startofpacket_o SHALL be 1 on the first beat of a packet only; ast_endofpacket_o SHALL be 1 on beat number beats only.
REQ-016 ast_empty_o SHALL equal last_empty on the EOP beat and 0 on all other beats.
REQ-017 ast_channel_o SHALL hold the latched channel on every beat of the packet.
REQ-018 While ast_valid_o=1 and ast_ready_i=0, all ast_* outputs SHALL hold stable.
REQ-019 ast_valid_o SHALL drop after an accepted beat when no new data is accepted in the same cycle.
REQ-020 The beat counter SHALL be LEN_W-EMPTY_W+1 bits wide; for len=2^LEN_W-1 the beat count SHALL be exact with no wrap.
REQ-021 After the EOP data word is accepted, the FSM SHALL return to IDLE on the next edge, so a new command can be accepted while the EOP beat is still stalled.
REQ-022 The next packet's first beat SHALL NOT overwrite a stalled EOP beat (REQ-013 guarantees this).
REQ-023 A single-beat packet (len 1..8) SHALL assert SOP and EOP on the same beat.

Reset
REQ-024 srst_i asserted SHALL immediately force: FSM=IDLE; ast_valid_o, ast_startofpacket_o, ast_endofpacket_o=0; ast_empty_o=0; ast_channel_o=0; counters=0.
REQ-025 ast_data_o SHALL reset to 0.
REQ-026 Reset mid-packet SHALL abandon the packet; no EOP SHALL be emitted for it.
REQ-027 Reset deassertion SHALL occur synchronously to clk_i, handled outside this block.

Configuration
REQ-028 Macro PACKET_FRAMER_STATS_EN SHALL add output pkt_cnt_o[31:0] counting EOP beats accepted by the sink, wrapping at 2^32, reset to 0.
REQ-029 Without PACKET_FRAMER_STATS_EN, pkt_cnt_o and its counter SHALL be absent.

Structure
REQ-030 Package ast_pkg SHALL hold the DWIDTH/EMPTY_W/LEN_W defaults, the bytes-per-beat constant and the FSM state enum typedef.
REQ-031 The block SHALL be a single module with no sub-module; the output register stage SHALL be inline.

Verification
REQ-032 cmd len=20, ch=1, 3 words, ready=1 -> 3 beats: SOP on beat 1, EOP on beat 3, empty=4 on beat 3, channel=1 throughout.
REQ-033 cmd len=8 -> single beat with SOP=EOP=1 and empty=0; len=1 -> single beat with empty=7.
REQ-034 len=24, ast_ready_i low for 5 cycles on beat 2 -> beat 2 held stable, data_ready_o=0, no data loss.
REQ-035 cmd len=0 -> cmd_ready_o pulse, no ast_valid_o, next command accepted the following cycle.
REQ-036 Back-to-back commands len=16 then len=9 with EOP stalled 2 cycles -> second SOP appears only after the first EOP is accepted; second packet empty=7.
REQ-037 srst_i asserted mid-packet (beat 2 of 4) -> outputs 0 that cycle, FSM IDLE, next command framed correctly starting with SOP.

Source files
------------

// File: rtl/ast_pkg.sv
// Shared defaults, beat geometry and FSM state type for the Avalon-ST packet framer.
package ast_pkg;
    localparam int DWIDTH_DEF     = 64;
    localparam int EMPTY_W_DEF    = 3;
    localparam int LEN_W_DEF      = 16;
    localparam int BYTES_PER_BEAT = 1 << EMPTY_W_DEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;
endpackage

// File: rtl/packet_framer.sv
// Frames raw payload words into Avalon-ST packets from a length/channel command.
// Build option PACKET_FRAMER_STATS_EN adds pkt_cnt_o, a wrapping count of EOP beats taken by the sink.
module packet_framer
    import ast_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int EMPTY_W = EMPTY_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic               cmd_channel_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [DWIDTH-1:0]  data_i,
    input  logic               data_valid_i,
    output logic               data_ready_o,
    output logic [DWIDTH-1:0]  ast_data_o,
    output logic               ast_valid_o,
    input  logic               ast_ready_i,
    output logic               ast_startofpacket_o,
    output logic               ast_endofpacket_o,
    output logic [EMPTY_W-1:0] ast_empty_o,
    output logic               ast_channel_o
`ifdef PACKET_FRAMER_STATS_EN
    ,
    output logic [31:0]        pkt_cnt_o
`endif
);
    // One extra bit so that the maximum length rounds up without wrapping.
    localparam int BCNT_W = LEN_W - EMPTY_W + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCNT_W-1:0]  r_beats_left;
    logic [EMPTY_W-1:0] r_last_empty;
    logic               r_channel;
    logic               r_first;

    logic [DWIDTH-1:0]  r_ast_data;
    logic               r_ast_valid;
    logic               r_ast_sop;
    logic               r_ast_eop;
    logic [EMPTY_W-1:0] r_ast_empty;
    logic               r_ast_channel;

    logic [LEN_W:0]     w_len_rnd;
    logic [BCNT_W-1:0]  w_cmd_beats;
    logic [EMPTY_W-1:0] w_cmd_empty;
    logic               w_cmd_load;
    logic               w_data_acc;
    logic               w_last_beat;

    assign w_len_rnd   = {1'b0, cmd_len_i} + (LEN_W+1)'((1 << EMPTY_W) - 1);
    assign w_cmd_beats = w_len_rnd[LEN_W:EMPTY_W];
    assign w_cmd_empty = EMPTY_W'(0) - cmd_len_i[EMPTY_W-1:0];

    assign cmd_ready_o  = (r_state == ST_IDLE);
    assign w_cmd_load   = cmd_valid_i & cmd_ready_o & (cmd_len_i != '0);
    // The output stage only takes a word when it is empty or draining, so a stalled EOP is never overwritten.
    assign data_ready_o = (r_state == ST_SEND) & (~r_ast_valid | ast_ready_i);
    assign w_data_acc   = data_valid_i & data_ready_o;
    assign w_last_beat  = (r_beats_left == BCNT_W'(1));

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i && (cmd_len_i != '0)) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_data_acc && w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_beats_left  <= '0;
            r_last_empty  <= '0;
            r_channel     <= 1'b0;
            r_first       <= 1'b0;
            r_ast_data    <= '0;
            r_ast_valid   <= 1'b0;
            r_ast_sop     <= 1'b0;
            r_ast_eop     <= 1'b0;
            r_ast_empty   <= '0;
            r_ast_channel <= 1'b0;
        end else begin
            if (w_cmd_load) begin
                r_beats_left <= w_cmd_beats;
                r_last_empty <= w_cmd_empty;
                r_channel    <= cmd_channel_i;
                r_first      <= 1'b1;
            end
            if (w_data_acc) begin
                r_ast_data    <= data_i;
                r_ast_valid   <= 1'b1;
                r_ast_sop     <= r_first;
                r_ast_eop     <= w_last_beat;
                r_ast_empty   <= w_last_beat ? r_last_empty : '0;
                r_ast_channel <= r_channel;
                r_first       <= 1'b0;
                r_beats_left  <= r_beats_left - BCNT_W'(1);
            end else if (ast_ready_i) begin
                r_ast_valid <= 1'b0;
            end
        end
    end

    assign ast_data_o          = r_ast_data;
    assign ast_valid_o         = r_ast_valid;
    assign ast_startofpacket_o = r_ast_sop;
    assign ast_endofpacket_o   = r_ast_eop;
    assign ast_empty_o         = r_ast_empty;
    assign ast_channel_o       = r_ast_channel;

`ifdef PACKET_FRAMER_STATS_EN
    logic [31:0] r_pkt_cnt;

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_pkt_cnt <= '0;
        end else if (r_ast_valid && ast_ready_i && r_ast_eop) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    assign pkt_cnt_o = r_pkt_cnt;
`endif
endmodule
